// File: rtl/freq_meter_seq.sv
// Frequency meter measurement sequencer: gated edge counting with three-decade
// auto-ranging, single-shot or continuous operation.
//
// state | meaning
// IDLE  | waiting for start or cont
// GATE  | counting window open, timer running
// EVAL  | one cycle to judge the count and pick the next range
// HOLD  | result held for the display, edges ignored
module freq_meter_seq #(
  parameter int GATE_BASE   = 100000000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int MAX_DISP    = 9999,
  parameter int CNT_W       = 24,
  parameter int FREQ_W      = 14
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              sigin,
  input  logic              start,
  input  logic              cont,
  output logic [FREQ_W-1:0] freq,
  output logic [1:0]        range,
  output logic              valid,
  output logic              overflow,
  output logic              gate,
  output logic              busy
);

  localparam int TMR_MAX = (GATE_BASE > HOLD_CYCLES) ? GATE_BASE : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]  G0     = TMR_W'(GATE_BASE);
  localparam logic [TMR_W-1:0]  G1     = TMR_W'(GATE_BASE / 10);
  localparam logic [TMR_W-1:0]  G2     = TMR_W'(GATE_BASE / 100);
  localparam logic [TMR_W-1:0]  HOLD_T = TMR_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0]  T_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0]  MAX_C  = CNT_W'(MAX_DISP);
  localparam logic [CNT_W-1:0]  LOW_C  = CNT_W'((MAX_DISP + 1) / 10);
  localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);
  localparam logic [FREQ_W-1:0] MAX_F  = FREQ_W'(MAX_DISP);

  typedef enum logic [1:0] {IDLE, GATE, EVAL, HOLD} state_t;

  state_t             state, state_nxt;
  logic               s1, s2, s3, rise;
  logic [CNT_W-1:0]   cnt;
  logic [TMR_W-1:0]   timer, gate_len;
  logic [1:0]         range_nxt;
  logic [FREQ_W-1:0]  freq_nxt;
  logic               ovf_nxt, upd, ld_gate, ld_hold;

  // two flops to resynchronise sigin, a third for the rising-edge compare
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sigin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_comb begin
    state_nxt = state;
    range_nxt = range;
    freq_nxt  = freq;
    ovf_nxt   = overflow;
    upd       = 1'b0;
    ld_gate   = 1'b0;
    ld_hold   = 1'b0;
    gate      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start || cont) begin
          state_nxt = GATE;
          ld_gate   = 1'b1;
        end
      end
      GATE: begin
        gate = 1'b1;
        if (timer == T_ONE) state_nxt = EVAL;
      end
      EVAL: begin
        if (cnt > MAX_C && range < 2'd2) begin
          // too many edges for this decade: retry immediately one decade coarser
          range_nxt = range + 2'd1;
          state_nxt = GATE;
          ld_gate   = 1'b1;
        end else begin
          upd       = 1'b1;
          state_nxt = HOLD;
          ld_hold   = 1'b1;
          if (cnt > MAX_C) begin
            freq_nxt = MAX_F;
            ovf_nxt  = 1'b1;
          end else begin
            freq_nxt = cnt[FREQ_W-1:0];
            ovf_nxt  = 1'b0;
            if (cnt < LOW_C && range != 2'd0) range_nxt = range - 2'd1;
          end
        end
      end
      HOLD: begin
        if (timer == T_ONE) begin
          state_nxt = cont ? GATE : IDLE;
          ld_gate   = cont;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // the window length follows the range that the coming gate will use
  always_comb begin
    case (range_nxt)
      2'd0:    gate_len = G0;
      2'd1:    gate_len = G1;
      default: gate_len = G2;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      cnt      <= '0;
      range    <= 2'd0;
      freq     <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      range    <= range_nxt;
      freq     <= freq_nxt;
      overflow <= ovf_nxt;
      valid    <= upd;
      if (ld_gate)             timer <= gate_len;
      else if (ld_hold)        timer <= HOLD_T;
      else if (timer != '0)    timer <= timer - T_ONE;
      if (ld_gate)             cnt <= '0;
      else if (state == GATE && rise && cnt != '1) cnt <= cnt + C_ONE;
    end
  end

endmodule

// File: tb/tb_freq_meter_seq.sv
// Directed bench for freq_meter_seq: a 999-count instance for ranging, continuous
// mode and reset abort, and a 40-count instance for overflow and range step-down.
module tb_freq_meter_seq;
  localparam int GB = 10000;
  localparam int HC = 20;

  logic sysclk = 1'b0;
  logic sigin = 1'b0;
  logic reset1 = 1'b1, reset2 = 1'b1;
  logic start1 = 1'b0, start2 = 1'b0, cont1 = 1'b0, cont2 = 1'b0;
  logic [13:0] freq1, freq2;
  logic [1:0]  range1, range2;
  logic valid1, valid2, ovf1, ovf2, gate1, gate2, busy1, busy2;

  int checks = 0, errors = 0;
  int per = 0, ph = 0;
  int vc1 = 0, vc2 = 0, run1 = 0, run2 = 0, glen1 = 0, glen2 = 0;

  freq_meter_seq #(.GATE_BASE(GB), .HOLD_CYCLES(HC), .MAX_DISP(999), .CNT_W(24), .FREQ_W(14)) dut1 (
    .sysclk(sysclk), .reset(reset1), .sigin(sigin), .start(start1), .cont(cont1),
    .freq(freq1), .range(range1), .valid(valid1), .overflow(ovf1), .gate(gate1), .busy(busy1));

  freq_meter_seq #(.GATE_BASE(GB), .HOLD_CYCLES(HC), .MAX_DISP(40), .CNT_W(24), .FREQ_W(14)) dut2 (
    .sysclk(sysclk), .reset(reset2), .sigin(sigin), .start(start2), .cont(cont2),
    .freq(freq2), .range(range2), .valid(valid2), .overflow(ovf2), .gate(gate2), .busy(busy2));

  always #5 sysclk = ~sysclk;

  // test signal: toggles every per/2 falling clock edges, held low when per < 2
  initial begin
    forever begin
      @(negedge sysclk);
      if (per >= 2) begin
        ph = ph + 1;
        if (ph >= per / 2) begin
          ph = 0;
          sigin = ~sigin;
        end
      end
    end
  end

  always @(negedge sysclk) begin
    if (valid1) vc1 <= vc1 + 1;
    if (valid2) vc2 <= vc2 + 1;
    if (gate1) run1 <= run1 + 1;
    else if (run1 != 0) begin glen1 <= run1; run1 <= 0; end
    if (gate2) run2 <= run2 + 1;
    else if (run2 != 0) begin glen2 <= run2; run2 <= 0; end
  end

  task automatic tick;
    @(negedge sysclk);
    #1;
  endtask

  task automatic set_per(input int p);
    @(negedge sysclk);
    per = p;
    ph = 0;
    sigin = 1'b0;
    #1;
  endtask

  task automatic pulse_start1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic pulse_start2;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
  endtask

  task automatic wait_valid1(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid1 === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid2(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid2 === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle1(output int n);
    n = 0;
    while (busy1 !== 1'b0 && n < 200) begin tick(); n++; end
  endtask

  task automatic wait_idle2(output int n);
    n = 0;
    while (busy2 !== 1'b0 && n < 200) begin tick(); n++; end
  endtask

  task automatic test_reset;
    tick();
    checks++;
    if ({freq1, range1, valid1, ovf1, gate1, busy1} !== 20'd0) begin
      errors++; $display("FAIL reset_dut1: got %h expected 0", {freq1, range1, valid1, ovf1, gate1, busy1});
    end
    checks++;
    if ({freq2, range2, valid2, ovf2, gate2, busy2} !== 20'd0) begin
      errors++; $display("FAIL reset_dut2: got %h expected 0", {freq2, range2, valid2, ovf2, gate2, busy2});
    end
    reset1 = 1'b0;
    reset2 = 1'b0;
    repeat (5) tick();
    checks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0 || vc1 != 0 || vc2 != 0) begin
      errors++; $display("FAIL idle_after_reset: busy %b%b valids %0d %0d expected idle, none", busy1, busy2, vc1, vc2);
    end
  endtask

  task automatic test_single;
    bit ok;
    int v0, n;
    set_per(100);
    repeat (5) tick();
    v0 = vc1;
    pulse_start1();
    wait_valid1(12000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_valid: got timeout expected valid"); end
    checks++;
    if (freq1 < 99 || freq1 > 101) begin errors++; $display("FAIL single_freq: got %0d expected 99..101", freq1); end
    checks++;
    if (range1 !== 2'd0 || ovf1 !== 1'b0) begin
      errors++; $display("FAIL single_range_ovf: got %0d/%b expected 0/0", range1, ovf1);
    end
    checks++;
    if (glen1 != GB) begin errors++; $display("FAIL single_gate_len: got %0d expected %0d", glen1, GB); end
    wait_idle1(n);
    checks++;
    if (n != HC) begin errors++; $display("FAIL single_hold_len: got %0d expected %0d", n, HC); end
    checks++;
    if (vc1 - v0 != 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", vc1 - v0); end
  endtask

  task automatic test_autorange;
    bit ok;
    int v0, n;
    set_per(4);
    repeat (5) tick();
    v0 = vc1;
    pulse_start1();
    wait_valid1(13000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL autorange_valid: got timeout expected valid"); end
    checks++;
    if (vc1 - v0 != 1) begin errors++; $display("FAIL autorange_no_early_valid: got %0d expected 1", vc1 - v0); end
    checks++;
    if (range1 !== 2'd1) begin errors++; $display("FAIL autorange_range: got %0d expected 1", range1); end
    checks++;
    if (freq1 < 249 || freq1 > 251 || ovf1 !== 1'b0) begin
      errors++; $display("FAIL autorange_freq: got %0d ovf %b expected 249..251 ovf 0", freq1, ovf1);
    end
    checks++;
    if (glen1 != GB / 10) begin errors++; $display("FAIL autorange_gate_len: got %0d expected %0d", glen1, GB / 10); end
    wait_idle1(n);
  endtask

  task automatic test_continuous;
    bit ok;
    int n;
    set_per(1000);
    repeat (5) tick();
    cont1 = 1'b1;
    pulse_start1();
    wait_valid1(1200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cont_valid1: got timeout expected valid"); end
    checks++;
    if (freq1 !== 14'd1 || range1 !== 2'd0) begin
      errors++; $display("FAIL cont_stepdown: got freq %0d range %0d expected 1/0", freq1, range1);
    end
    n = 0;
    while (gate1 !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (gate1 !== 1'b1) begin errors++; $display("FAIL cont_restart: got gate %b expected 1", gate1); end
    cont1 = 1'b0;
    wait_valid1(10500, ok);
    checks++;
    if (!ok || freq1 < 9 || freq1 > 11 || range1 !== 2'd0) begin
      errors++; $display("FAIL cont_final: got freq %0d range %0d expected 9..11/0", freq1, range1);
    end
    checks++;
    if (glen1 != GB) begin errors++; $display("FAIL cont_gate_len: got %0d expected %0d", glen1, GB); end
    wait_idle1(n);
    checks++;
    if (n != HC) begin errors++; $display("FAIL cont_drop_idle: got %0d expected %0d", n, HC); end
  endtask

  task automatic test_reset_mid_gate;
    bit ok;
    int v0, n;
    set_per(100);
    repeat (5) tick();
    pulse_start1();
    n = 0;
    while (gate1 !== 1'b1 && n < 10) begin tick(); n++; end
    repeat (500) tick();
    v0 = vc1;
    reset1 = 1'b1;
    #1;
    checks++;
    if ({freq1, range1, valid1, ovf1, gate1, busy1} !== 20'd0) begin
      errors++; $display("FAIL abort_outputs: got %h expected 0", {freq1, range1, valid1, ovf1, gate1, busy1});
    end
    repeat (3) tick();
    reset1 = 1'b0;
    repeat (30) tick();
    checks++;
    if (vc1 != v0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL abort_no_valid: got %0d valids busy %b expected 0/0", vc1 - v0, busy1);
    end
    pulse_start1();
    wait_valid1(12000, ok);
    checks++;
    if (!ok || freq1 < 99 || freq1 > 101 || range1 !== 2'd0) begin
      errors++; $display("FAIL abort_clean_run: got freq %0d range %0d expected 99..101/0", freq1, range1);
    end
    checks++;
    if (glen1 != GB) begin errors++; $display("FAIL abort_gate_len: got %0d expected %0d", glen1, GB); end
    wait_idle1(n);
  endtask

  task automatic test_overflow_stepdown;
    bit ok;
    int v0, n;
    set_per(2);
    repeat (5) tick();
    v0 = vc2;
    pulse_start2();
    wait_valid2(12000, ok);
    checks++;
    if (!ok || vc2 - v0 != 1) begin errors++; $display("FAIL ovf_valid: got %0d valids expected 1", vc2 - v0); end
    checks++;
    if (freq2 !== 14'd40 || ovf2 !== 1'b1 || range2 !== 2'd2) begin
      errors++; $display("FAIL ovf_result: got freq %0d ovf %b range %0d expected 40/1/2", freq2, ovf2, range2);
    end
    checks++;
    if (glen2 != GB / 100) begin errors++; $display("FAIL ovf_gate_len: got %0d expected %0d", glen2, GB / 100); end
    set_per(1000);
    cont2 = 1'b1;
    wait_valid2(300, ok);
    checks++;
    if (!ok || freq2 > 1 || ovf2 !== 1'b0 || range2 !== 2'd1) begin
      errors++; $display("FAIL step_2to1: got freq %0d ovf %b range %0d expected 0..1/0/1", freq2, ovf2, range2);
    end
    wait_valid2(1200, ok);
    checks++;
    if (!ok || freq2 !== 14'd1 || range2 !== 2'd0) begin
      errors++; $display("FAIL step_1to0: got freq %0d range %0d expected 1/0", freq2, range2);
    end
    n = 0;
    while (gate2 !== 1'b1 && n < 40) begin tick(); n++; end
    cont2 = 1'b0;
    wait_valid2(10500, ok);
    checks++;
    if (!ok || freq2 < 9 || freq2 > 11 || range2 !== 2'd0 || ovf2 !== 1'b0) begin
      errors++; $display("FAIL step_final: got freq %0d range %0d ovf %b expected 9..11/0/0", freq2, range2, ovf2);
    end
    wait_idle2(n);
    checks++;
    if (n != HC) begin errors++; $display("FAIL step_idle: got %0d expected %0d", n, HC); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_autorange();
    test_continuous();
    test_reset_mid_gate();
    test_overflow_stepdown();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
